// File: rtl/sdp_nrdma_eg_pkg.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_eg_pkg
// Shared definitions for the SDP NRDMA egress response path.
//   RSP_DW / ATOM_DW / MASK_W : response, atom and half-mask widths
//   CNT_W_DEF                 : default atom counter width
//   nrdma_rsp_t               : {mask, data} read-response payload
//   hold_st_e                 : holding-register state of the unpacker
// ---------------------------------------------------------------------------
package sdp_nrdma_eg_pkg;

  localparam int RSP_DW    = 512;
  localparam int ATOM_DW   = 256;
  localparam int MASK_W    = RSP_DW / ATOM_DW;
  localparam int CNT_W_DEF = 14;

  // Mask sits above the data so the packed layout matches {mask, data}.
  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [RSP_DW-1:0] data;
  } nrdma_rsp_t;

  typedef enum logic [1:0] {
    HOLD_EMPTY = 2'd0,
    HOLD_LO    = 2'd1,
    HOLD_HI    = 2'd2
  } hold_st_e;

endpackage

// File: rtl/sdp_nrdma_eg_rsp_unpack_if.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_eg_rsp_unpack_if
// Groups the two streaming channels of the response unpacker.
//   dma_rd_rsp_vld/rdy/pd : 514-bit read response in ({mask, data})
//   atom_vld/rdy/pd/last  : 256-bit atom out, last flag marks end of layer
// Modports:
//   master : upstream/downstream side (drives response, drives atom_rdy)
//   slave  : the unpacker itself
// ---------------------------------------------------------------------------
interface sdp_nrdma_eg_rsp_unpack_if;
  import sdp_nrdma_eg_pkg::*;

  logic               dma_rd_rsp_vld;
  logic               dma_rd_rsp_rdy;
  nrdma_rsp_t         dma_rd_rsp_pd;

  logic               atom_vld;
  logic               atom_rdy;
  logic [ATOM_DW-1:0] atom_pd;
  logic               atom_last;

  modport master (
    output dma_rd_rsp_vld, dma_rd_rsp_pd, atom_rdy,
    input  dma_rd_rsp_rdy, atom_vld, atom_pd, atom_last
  );

  modport slave (
    input  dma_rd_rsp_vld, dma_rd_rsp_pd, atom_rdy,
    output dma_rd_rsp_rdy, atom_vld, atom_pd, atom_last
  );

endinterface

// File: rtl/sdp_nrdma_eg_atom_cnt.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_eg_atom_cnt
// Counts atoms of a layer against a programmed total (atoms minus one).
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   op_load_i        : clear counter and latch cfg_total_i
//   cfg_total_i      : atoms in layer minus one
//   atom_vld_i       : an atom is being presented
//   atom_fire_i      : atom handshake this cycle
//   atom_last_o      : presented atom is the last of the layer
//   layer_done_o     : registered pulse after the last atom's handshake
// ---------------------------------------------------------------------------
module sdp_nrdma_eg_atom_cnt #(
  parameter int CNT_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             op_load_i,
  input  logic [CNT_W-1:0] cfg_total_i,
  input  logic             atom_vld_i,
  input  logic             atom_fire_i,
  output logic             atom_last_o,
  output logic             layer_done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             done_q, done_d;

  // Qualified by atom_vld so the flag is low while idle (cnt == total == 0
  // right after reset).
  assign atom_last_o  = atom_vld_i & (cnt_q == total_q);
  assign layer_done_o = done_q;

  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    done_d  = 1'b0;
    // A load coinciding with a handshake discards that atom from the count.
    if (op_load_i) begin
      cnt_d   = '0;
      total_d = cfg_total_i;
    end else if (atom_fire_i) begin
      if (atom_last_o) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      total_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/sdp_nrdma_eg_rsp_unpack.sv
// ---------------------------------------------------------------------------
// sdp_nrdma_eg_rsp_unpack
// Egress read-response unpacker. Takes {mask[1:0], data[511:0]} responses
// and emits one 256-bit atom per set mask bit, lower half first. Returns one
// latency-FIFO credit per fully consumed response (or per mask-00 response).
// Ports:
//   nvdla_core_clk, nvdla_core_rst : clock, asynchronous active-high reset
//   bus (slave)                    : response in / atom out channels
//   op_load, cfg_atom_total        : layer start, atoms in layer minus one
//   layer_done                     : pulse after the layer's last atom
//   lat_fifo_pop                   : one-cycle credit per response
//   mask_err                       : sticky, a mask-00 response was seen
//   perf_stall_cnt                 : only with SDP_NRDMA_EG_UNPACK_PERF_EN,
//                                    saturating count of stalled atom cycles
// ---------------------------------------------------------------------------
module sdp_nrdma_eg_rsp_unpack
  import sdp_nrdma_eg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rst,
  sdp_nrdma_eg_rsp_unpack_if.slave        bus,
  input  logic                            op_load,
  input  logic [CNT_W-1:0]                cfg_atom_total,
  output logic                            layer_done,
  output logic                            lat_fifo_pop,
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  output logic [31:0]                     perf_stall_cnt,
`endif
  output logic                            mask_err
);

  hold_st_e            hold_st_q, hold_st_d;
  logic [RSP_DW-1:0]   hold_data_q, hold_data_d;
  logic                hold_m1_q, hold_m1_d;
  logic                pop_q, pop_d;
  logic [1:0]          owed_q, owed_d;
  logic                mask_err_q, mask_err_d;

  logic                atom_vld;
  logic                atom_fire;
  logic                last_half;
  logic                rsp_rdy;
  logic                rsp_acc;
  logic                rsp_done;
  logic                null_acc;
  logic [2:0]          credit_sum;
  logic [2:0]          credit_left;

  // Handshake decode
  always_comb begin
    atom_vld  = (hold_st_q != HOLD_EMPTY);
    atom_fire = atom_vld & bus.atom_rdy;
    last_half = (hold_st_q == HOLD_HI) | ((hold_st_q == HOLD_LO) & ~hold_m1_q);
    rsp_done  = atom_fire & last_half;
    rsp_rdy   = (hold_st_q == HOLD_EMPTY) | rsp_done;
    rsp_acc   = bus.dma_rd_rsp_vld & rsp_rdy;
    null_acc  = rsp_acc & (bus.dma_rd_rsp_pd.mask == '0);
  end

  assign bus.dma_rd_rsp_rdy = rsp_rdy;
  assign bus.atom_vld       = atom_vld;

  always_comb begin
    case (hold_st_q)
      HOLD_LO: bus.atom_pd = hold_data_q[ATOM_DW-1:0];
      HOLD_HI: bus.atom_pd = hold_data_q[RSP_DW-1:ATOM_DW];
      default: bus.atom_pd = '0;
    endcase
  end

  // Unpack FSM next state; an accept in the same cycle as the last half
  // overrides the drop to EMPTY, which keeps back-to-back at full rate.
  always_comb begin
    hold_st_d   = hold_st_q;
    hold_data_d = hold_data_q;
    hold_m1_d   = hold_m1_q;
    if (atom_fire) begin
      hold_st_d = ((hold_st_q == HOLD_LO) && hold_m1_q) ? HOLD_HI : HOLD_EMPTY;
    end
    if (rsp_acc) begin
      hold_data_d = bus.dma_rd_rsp_pd.data;
      hold_m1_d   = bus.dma_rd_rsp_pd.mask[1];
      case (bus.dma_rd_rsp_pd.mask)
        2'b00:   hold_st_d = HOLD_EMPTY;
        2'b10:   hold_st_d = HOLD_HI;
        default: hold_st_d = HOLD_LO;
      endcase
    end
  end

  // Credit return. A response can finish in the same cycle a mask-00
  // response is accepted, giving two credits at once; the extra one is
  // owed and emitted on a following cycle.
  always_comb begin
    credit_sum  = {1'b0, owed_q} + {2'b00, rsp_done} + {2'b00, null_acc};
    pop_d       = (credit_sum != 3'd0);
    credit_left = credit_sum - {2'b00, pop_d};
    owed_d      = credit_left[2] ? 2'd3 : credit_left[1:0];
    mask_err_d  = mask_err_q | null_acc;
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      hold_st_q  <= HOLD_EMPTY;
      pop_q      <= 1'b0;
      owed_q     <= 2'd0;
      mask_err_q <= 1'b0;
    end else begin
      hold_st_q  <= hold_st_d;
      pop_q      <= pop_d;
      owed_q     <= owed_d;
      mask_err_q <= mask_err_d;
    end
  end

  // Payload is only observed while the state is non-empty, so it needs no reset.
  always_ff @(posedge nvdla_core_clk) begin
    hold_data_q <= hold_data_d;
    hold_m1_q   <= hold_m1_d;
  end

  assign lat_fifo_pop = pop_q;
  assign mask_err     = mask_err_q;

  sdp_nrdma_eg_atom_cnt #(
    .CNT_W (CNT_W)
  ) u_atom_cnt (
    .clk_i        (nvdla_core_clk),
    .rst_i        (nvdla_core_rst),
    .op_load_i    (op_load),
    .cfg_total_i  (cfg_atom_total),
    .atom_vld_i   (atom_vld),
    .atom_fire_i  (atom_fire),
    .atom_last_o  (bus.atom_last),
    .layer_done_o (layer_done)
  );

`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (op_load) begin
      perf_d = '0;
    end else if (atom_vld && !bus.atom_rdy && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_sdp_nrdma_eg_rsp_unpack.sv
// ---------------------------------------------------------------------------
// tb_sdp_nrdma_eg_rsp_unpack
// Directed testbench for the egress response unpacker. Optional perf counter
// checks are built when SDP_NRDMA_EG_UNPACK_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_sdp_nrdma_eg_rsp_unpack;
  import sdp_nrdma_eg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_load;
  logic [13:0] cfg_atom_total;
  logic        layer_done;
  logic        lat_fifo_pop;
  logic        mask_err;
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sdp_nrdma_eg_rsp_unpack_if bus ();

  sdp_nrdma_eg_rsp_unpack #(.CNT_W(14)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus),
    .op_load        (op_load),
    .cfg_atom_total (cfg_atom_total),
    .layer_done     (layer_done),
    .lat_fifo_pop   (lat_fifo_pop),
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .mask_err       (mask_err)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

  function automatic nrdma_rsp_t mk(input logic [1:0] m, input logic [255:0] hi,
                                    input logic [255:0] lo);
    return {m, hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dma_rd_rsp_vld = 1'b0;
    bus.dma_rd_rsp_pd  = '0;
    bus.atom_rdy       = 1'b0;
    op_load            = 1'b0;
    cfg_atom_total     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL rst_atom_vld got %b exp 0", bus.atom_vld); end
    checks++; if (bus.atom_pd !== 256'd0) begin errors++; $display("FAIL rst_atom_pd got %h exp 0", bus.atom_pd); end
    checks++; if (bus.atom_last !== 1'b0) begin errors++; $display("FAIL rst_atom_last got %b exp 0", bus.atom_last); end
    checks++; if (layer_done !== 1'b0) begin errors++; $display("FAIL rst_layer_done got %b exp 0", layer_done); end
    checks++; if (lat_fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %b exp 0", lat_fifo_pop); end
    checks++; if (mask_err !== 1'b0) begin errors++; $display("FAIL rst_mask_err got %b exp 0", mask_err); end
    rst = 1'b0;
    tick();
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rst_rsp_rdy got %b exp 1", bus.dma_rd_rsp_rdy); end
  endtask

  task automatic test_mask11();
    logic [255:0] a, b;
    a = {8{32'hAAAA_0001}};
    b = {8{32'hBBBB_0002}};
    bus.atom_rdy       = 1'b1;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b11, b, a);
    #1;
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL m11_acc_rdy got %b exp 1", bus.dma_rd_rsp_rdy); end
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    #1;
    checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, a}) begin errors++; $display("FAIL m11_atom_a got %b/%h exp 1/%h", bus.atom_vld, bus.atom_pd, a); end
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b0) begin errors++; $display("FAIL m11_rdy_during_a got %b exp 0", bus.dma_rd_rsp_rdy); end
    checks++; if (bus.atom_last !== 1'b1) begin errors++; $display("FAIL m11_last_total0 got %b exp 1", bus.atom_last); end
    tick();
    checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, b}) begin errors++; $display("FAIL m11_atom_b got %b/%h exp 1/%h", bus.atom_vld, bus.atom_pd, b); end
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL m11_rdy_during_b got %b exp 1", bus.dma_rd_rsp_rdy); end
    checks++; if (lat_fifo_pop !== 1'b0) begin errors++; $display("FAIL m11_pop_early got %b exp 0", lat_fifo_pop); end
    tick();
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL m11_idle got %b exp 0", bus.atom_vld); end
    checks++; if (lat_fifo_pop !== 1'b1) begin errors++; $display("FAIL m11_pop got %b exp 1", lat_fifo_pop); end
    checks++; if (layer_done !== 1'b1) begin errors++; $display("FAIL m11_layer_done got %b exp 1", layer_done); end
    tick();
    checks++; if (lat_fifo_pop !== 1'b0) begin errors++; $display("FAIL m11_pop_once got %b exp 0", lat_fifo_pop); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d [4];
    int pops;
    for (int i = 0; i < 4; i++) d[i] = {8{32'h5A5A_0000 | i}};
    pops = 0;
    bus.atom_rdy       = 1'b1;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b01, JUNK, d[0]);
    #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.dma_rd_rsp_pd = mk(2'b01, JUNK, d[i+1]);
      else       bus.dma_rd_rsp_vld = 1'b0;
      #1;
      pops += int'(lat_fifo_pop);
      checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, d[i]}) begin errors++; $display("FAIL b2b_atom%0d got %b/%h exp 1/%h", i, bus.atom_vld, bus.atom_pd, d[i]); end
      checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got %b exp 1", i, bus.dma_rd_rsp_rdy); end
      tick();
    end
    pops += int'(lat_fifo_pop);
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", bus.atom_vld); end
    checks++; if (pops !== 4) begin errors++; $display("FAIL b2b_credits got %0d exp 4", pops); end
    tick();
  endtask

  task automatic test_stall();
    logic [255:0] c, d;
    c = {8{32'hC0C0_0003}};
    d = {8{32'hD0D0_0004}};
    bus.atom_rdy       = 1'b0;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b11, d, c);
    #1;
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, c}) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/%h", i, bus.atom_vld, bus.atom_pd, c); end
      tick();
    end
    bus.atom_rdy = 1'b1;
    #1;
    checks++; if (bus.atom_pd !== c) begin errors++; $display("FAIL stall_lo got %h exp %h", bus.atom_pd, c); end
    tick();
    checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, d}) begin errors++; $display("FAIL stall_hi got %b/%h exp 1/%h", bus.atom_vld, bus.atom_pd, d); end
    tick();
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", bus.atom_vld); end
`ifdef SDP_NRDMA_EG_UNPACK_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_perf got %0d exp 3", perf_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_layer();
    logic [255:0] lo [3];
    logic [255:0] hi [3];
    logic [255:0] exp_pd [6];
    int ri, k, dones, last_cyc, done_cyc;
    logic acc;
    for (int r = 0; r < 3; r++) begin
      lo[r] = {8{32'h1000_0000 | r}};
      hi[r] = {8{32'h2000_0000 | r}};
      exp_pd[2*r]   = lo[r];
      exp_pd[2*r+1] = hi[r];
    end
    op_load        = 1'b1;
    cfg_atom_total = 14'd5;
    #1;
    tick();
    op_load = 1'b0;
    ri = 0; k = 0; dones = 0; last_cyc = -10; done_cyc = -20;
    bus.atom_rdy       = 1'b1;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b11, hi[0], lo[0]);
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (layer_done) begin dones++; done_cyc = cyc; end
      if (bus.atom_vld && k < 6) begin
        checks++; if (bus.atom_pd !== exp_pd[k]) begin errors++; $display("FAIL layer_atom%0d got %h exp %h", k, bus.atom_pd, exp_pd[k]); end
        checks++; if (bus.atom_last !== (k == 5)) begin errors++; $display("FAIL layer_last%0d got %b exp %b", k, bus.atom_last, (k == 5)); end
        if (k == 5) last_cyc = cyc;
        k++;
      end
      acc = bus.dma_rd_rsp_vld & bus.dma_rd_rsp_rdy;
      tick();
      if (acc) begin
        ri++;
        if (ri < 3) bus.dma_rd_rsp_pd = mk(2'b11, hi[ri], lo[ri]);
        else        bus.dma_rd_rsp_vld = 1'b0;
      end
    end
    checks++; if (k !== 6) begin errors++; $display("FAIL layer_atom_count got %0d exp 6", k); end
    checks++; if (last_cyc !== 6) begin errors++; $display("FAIL layer_last_cycle got %0d exp 6", last_cyc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL layer_done_count got %0d exp 1", dones); end
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL layer_done_cycle got %0d exp 7", done_cyc); end
    checks++; if (dut.u_atom_cnt.cnt_q !== 14'd0) begin errors++; $display("FAIL layer_cnt_clear got %0d exp 0", dut.u_atom_cnt.cnt_q); end
  endtask

  task automatic test_mask00();
    bus.atom_rdy       = 1'b1;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b00, JUNK, JUNK);
    #1;
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL m00_rdy got %b exp 1", bus.dma_rd_rsp_rdy); end
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    #1;
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL m00_no_atom got %b exp 0", bus.atom_vld); end
    checks++; if (lat_fifo_pop !== 1'b1) begin errors++; $display("FAIL m00_pop got %b exp 1", lat_fifo_pop); end
    checks++; if (mask_err !== 1'b1) begin errors++; $display("FAIL m00_err got %b exp 1", mask_err); end
    tick();
    checks++; if (lat_fifo_pop !== 1'b0) begin errors++; $display("FAIL m00_pop_once got %b exp 0", lat_fifo_pop); end
    checks++; if (mask_err !== 1'b1) begin errors++; $display("FAIL m00_err_sticky got %b exp 1", mask_err); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] e, f;
    int pops;
    e = {8{32'hE0E0_0005}};
    f = {8{32'hF0F0_0006}};
    pops = 0;
    bus.atom_rdy       = 1'b1;
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd  = mk(2'b11, f, e);
    #1;
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    tick();
    bus.atom_rdy = 1'b0;
    #1;
    checks++; if ({bus.atom_vld, bus.atom_pd} !== {1'b1, f}) begin errors++; $display("FAIL rmid_in_hi got %b/%h exp 1/%h", bus.atom_vld, bus.atom_pd, f); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL rmid_vld_drop got %b exp 0", bus.atom_vld); end
    checks++; if (bus.atom_pd !== 256'd0) begin errors++; $display("FAIL rmid_pd_clear got %h exp 0", bus.atom_pd); end
    checks++; if (mask_err !== 1'b0) begin errors++; $display("FAIL rmid_err_clear got %b exp 0", mask_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pops += int'(lat_fifo_pop);
    end
    checks++; if (pops !== 0) begin errors++; $display("FAIL rmid_no_credit got %0d exp 0", pops); end
    checks++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rdy got %b exp 1", bus.dma_rd_rsp_rdy); end
    checks++; if (bus.atom_vld !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b exp 0", bus.atom_vld); end
  endtask

  initial begin
    test_reset();
    test_mask11();
    test_back_to_back();
    test_stall();
    test_layer();
    test_mask00();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
